vga_timing_ctrl: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_timing_ctrl_if.sv | 41 ++++
 rtl/vga_axis_counter.sv | 77 +++++++
 rtl/vga_timing_ctrl.sv | 109 ++++++++++
 tb/tb_vga_timing_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 timing constants and raster phase encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);

    typedef enum logic [1:0] {
        ACT  = 2'd0,
        FP   = 2'd1,
        SYNC = 2'd2,
        BP   = 2'd3
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl_if
// Description : Pixel strobe in, raster timing out. VGA_FRAME_CNT_EN adds frame_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_ctrl_if
    import vga_timing_pkg::*;
#(
    parameter int HW_P = HW,
    parameter int VW_P = VW
);
    logic            pix_en;
    logic            hsync;
    logic            vsync;
    logic            active;
    logic [HW_P-1:0] hcount;
    logic [VW_P-1:0] vcount;
    logic            frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]     frame_cnt;
`endif

    modport master (
        input  pix_en,
`ifdef VGA_FRAME_CNT_EN
        output frame_cnt,
`endif
        output hsync, vsync, active, hcount, vcount, frame_start
    );

    modport slave (
        output pix_en,
`ifdef VGA_FRAME_CNT_EN
        input  frame_cnt,
`endif
        input  hsync, vsync, active, hcount, vcount, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: position counter plus ACT/FP/SYNC/BP phase FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int W = 10
)(
    input  wire          clk,
    input  wire          rst,
    input  wire          i_step,
    input  wire [W-1:0]  i_len_act,
    input  wire [W-1:0]  i_len_fp,
    input  wire [W-1:0]  i_len_sync,
    input  wire [W-1:0]  i_len_bp,
    output logic [W-1:0] o_count,
    output phase_t       o_phase,
    output logic         o_wrap,
    output logic         o_sync_n
);
    localparam logic [W-1:0] C_ONE = W'(1);

    logic [W-1:0] w_b_fp;
    logic [W-1:0] w_b_sync;
    logic [W-1:0] w_b_bp;
    logic [W-1:0] w_last;
    logic [W-1:0] w_count_nxt;
    phase_t       w_phase_nxt;

    logic [W-1:0] r_count;
    phase_t       r_phase;
    logic         r_sync_n;

    // Phase boundaries expressed as the first count of each phase.
    assign w_b_fp   = i_len_act;
    assign w_b_sync = w_b_fp + i_len_fp;
    assign w_b_bp   = w_b_sync + i_len_sync;
    assign w_last   = w_b_bp + i_len_bp - C_ONE;

    assign o_wrap      = i_step && (r_count == w_last);
    assign w_count_nxt = !i_step ? r_count : (o_wrap ? '0 : r_count + C_ONE);

    always_comb begin
        w_phase_nxt = r_phase;
        if (i_step) begin
            case (r_phase)
                ACT:     if (w_count_nxt == w_b_fp)   w_phase_nxt = FP;
                FP:      if (w_count_nxt == w_b_sync) w_phase_nxt = SYNC;
                SYNC:    if (w_count_nxt == w_b_bp)   w_phase_nxt = BP;
                BP:      if (o_wrap)                  w_phase_nxt = ACT;
                default:                              w_phase_nxt = BP;
            endcase
        end
    end

    // Reset parks on the last back-porch position so the first step lands on 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= w_last;
            r_phase  <= BP;
            r_sync_n <= 1'b1;
        end else begin
            r_count  <= w_count_nxt;
            r_phase  <= w_phase_nxt;
            r_sync_n <= (w_phase_nxt != SYNC);
        end
    end

    assign o_count  = r_count;
    assign o_phase  = r_phase;
    assign o_sync_n = r_sync_n;

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl
// Description : VGA raster timing generator; optional VGA_FRAME_CNT_EN frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP
)(
    input  wire               clk,
    input  wire               rst,
    vga_timing_ctrl_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] C_H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] C_H_FP   = HW'(H_FP);
    localparam logic [HW-1:0] C_H_SYNC = HW'(H_SYNC);
    localparam logic [HW-1:0] C_H_BP   = HW'(H_BP);
    localparam logic [VW-1:0] C_V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] C_V_FP   = VW'(V_FP);
    localparam logic [VW-1:0] C_V_SYNC = VW'(V_SYNC);
    localparam logic [VW-1:0] C_V_BP   = VW'(V_BP);

    logic [HW-1:0] w_hcount;
    logic [VW-1:0] w_vcount;
    phase_t        w_h_phase;
    phase_t        w_v_phase;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_v_step;
    logic          w_h_sync_n;
    logic          w_v_sync_n;
    logic          r_frame_start;

    assign w_v_step = bus.pix_en && w_h_wrap;

    vga_axis_counter #(.W(HW)) u_h_axis (
        .clk        (clk),
        .rst        (rst),
        .i_step     (bus.pix_en),
        .i_len_act  (C_H_ACT),
        .i_len_fp   (C_H_FP),
        .i_len_sync (C_H_SYNC),
        .i_len_bp   (C_H_BP),
        .o_count    (w_hcount),
        .o_phase    (w_h_phase),
        .o_wrap     (w_h_wrap),
        .o_sync_n   (w_h_sync_n)
    );

    vga_axis_counter #(.W(VW)) u_v_axis (
        .clk        (clk),
        .rst        (rst),
        .i_step     (w_v_step),
        .i_len_act  (C_V_ACT),
        .i_len_fp   (C_V_FP),
        .i_len_sync (C_V_SYNC),
        .i_len_bp   (C_V_BP),
        .o_count    (w_vcount),
        .o_phase    (w_v_phase),
        .o_wrap     (w_v_wrap),
        .o_sync_n   (w_v_sync_n)
    );

    // A vertical wrap is exactly the pix_en edge that loads (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_v_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
        end else if (w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign bus.frame_cnt = r_frame_cnt;
`endif

    assign bus.hcount      = w_hcount;
    assign bus.vcount      = w_vcount;
    assign bus.hsync       = w_h_sync_n;
    assign bus.vsync       = w_v_sync_n;
    assign bus.active      = (w_h_phase == ACT) && (w_v_phase == ACT);
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_ctrl
// Description : Checks a default-timing and a reduced-timing instance against a raster model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVA = 480, AVF = 10, AVS = 2,  AVB = 33;
    localparam int AHT = AHA + AHF + AHS + AHB;
    localparam int AVT = AVA + AVF + AVS + AVB;
    localparam int BHA = 16, BHF = 2, BHS = 4, BHB = 3;
    localparam int BVA = 8,  BVF = 2, BVS = 2, BVB = 3;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    vga_timing_ctrl_if #(.HW_P(10), .VW_P(10)) bus_a();
    vga_timing_ctrl_if #(.HW_P(5),  .VW_P(4))  bus_b();
    assign bus_a.pix_en = pix_en;
    assign bus_b.pix_en = pix_en;

    vga_timing_ctrl dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));

    vga_timing_ctrl #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: pixel strobes seen since reset, and whether the last edge had pix_en.
    longint p;
    bit     pe_last;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p       <= 0;
            pe_last <= 1'b0;
        end else begin
            if (pix_en) p <= p + 1;
            pe_last <= pix_en;
        end
    end

    function automatic void model(input longint pc, input bit pl,
                                  input int ha, hf, hs, ht, va, vf, vs, vt,
                                  output int h, output int v,
                                  output bit hn, output bit vn, output bit ac,
                                  output bit fs, output int fc);
        longint idx;
        if (pc == 0) begin
            h  = ht - 1;
            v  = vt - 1;
            fs = 1'b0;
            fc = 0;
        end else begin
            idx = (pc - 1) % (ht * vt);
            h   = int'(idx % ht);
            v   = int'(idx / ht);
            fs  = pl && (idx == 0);
            fc  = int'(((pc - 1) / (ht * vt) + 1) % 65536);
        end
        hn = !(h >= ha + hf && h < ha + hf + hs);
        vn = !(v >= va + vf && v < va + vf + vs);
        ac = (h < ha) && (v < va);
    endfunction

    always @(posedge clk) begin
        int h, v, fc;
        bit hn, vn, ac, fs;
        #1;
        model(p, pe_last, AHA, AHF, AHS, AHT, AVA, AVF, AVS, AVT, h, v, hn, vn, ac, fs, fc);
`ifdef VGA_FRAME_CNT_EN
        cmp("model_a", {bus_a.frame_cnt, bus_a.hcount, bus_a.vcount, bus_a.hsync, bus_a.vsync, bus_a.active, bus_a.frame_start},
                       {16'(fc), 10'(h), 10'(v), hn, vn, ac, fs});
`else
        cmp("model_a", {bus_a.hcount, bus_a.vcount, bus_a.hsync, bus_a.vsync, bus_a.active, bus_a.frame_start},
                       {10'(h), 10'(v), hn, vn, ac, fs});
`endif
        model(p, pe_last, BHA, BHF, BHS, BHT, BVA, BVF, BVS, BVT, h, v, hn, vn, ac, fs, fc);
`ifdef VGA_FRAME_CNT_EN
        cmp("model_b", {bus_b.frame_cnt, bus_b.hcount, bus_b.vcount, bus_b.hsync, bus_b.vsync, bus_b.active, bus_b.frame_start},
                       {16'(fc), 5'(h), 4'(v), hn, vn, ac, fs});
`else
        cmp("model_b", {bus_b.hcount, bus_b.vcount, bus_b.hsync, bus_b.vsync, bus_b.active, bus_b.frame_start},
                       {5'(h), 4'(v), hn, vn, ac, fs});
`endif
    end

    bit fs_a_seen, fs_b_seen;

    task automatic step_pix();
        @(negedge clk) pix_en = 1'b1;
        @(posedge clk) #1;
        fs_a_seen = bus_a.frame_start;
        fs_b_seen = bus_b.frame_start;
        @(negedge clk) pix_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int hlow, hmin, hmax, first_inact, chg, fsh, n, vlow, vmin, vmax, nfs, afs, cyc;
    int fs_t[3];
    bit found;
    logic [31:0] snap;

    initial begin
        repeat (3) @(negedge clk);
        cmp("reset_a", {bus_a.hcount, bus_a.vcount, bus_a.hsync, bus_a.vsync, bus_a.active, bus_a.frame_start},
                       {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0});
        cmp("reset_b", {bus_b.hcount, bus_b.vcount, bus_b.active}, {5'd24, 4'd14, 1'b0});
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // First strobe after reset lands on (0,0) with a single-clk frame_start.
        @(negedge clk) pix_en = 1'b1;
        @(posedge clk) #1;
        cmp("first_pix_a", {bus_a.hcount, bus_a.vcount, bus_a.hsync, bus_a.vsync, bus_a.active, bus_a.frame_start},
                           {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1});
        @(negedge clk) pix_en = 1'b0;
        @(posedge clk) #1;
        cmp("fs_one_clk", {bus_a.frame_start, bus_b.frame_start}, 2'b00);
        repeat (2) @(negedge clk);

        hlow = 0; hmin = 9999; hmax = -1; first_inact = -1;
        for (int i = 0; i < AHT; i++) begin
            step_pix();
            if (!bus_a.hsync) begin
                hlow++;
                if (int'(bus_a.hcount) < hmin) hmin = int'(bus_a.hcount);
                if (int'(bus_a.hcount) > hmax) hmax = int'(bus_a.hcount);
            end
            if (!bus_a.active && first_inact < 0 && bus_a.vcount == 10'd0) first_inact = int'(bus_a.hcount);
        end
        cmp("hsync_low_count", 64'(hlow), 64'd96);
        cmp("hsync_first", 64'(hmin), 64'd656);
        cmp("hsync_last", 64'(hmax), 64'd751);
        cmp("active_low_from", 64'(first_inact), 64'd640);
        cmp("line_length", {bus_a.hcount, bus_a.vcount}, {10'd0, 10'd1});

        for (int i = 0; i < 100; i++) step_pix();
        snap = {bus_a.hcount, bus_a.vcount, bus_a.hsync, bus_a.vsync, bus_a.active, bus_b.hcount, bus_b.vcount};
        chg = 0; fsh = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({bus_a.hcount, bus_a.vcount, bus_a.hsync, bus_a.vsync, bus_a.active, bus_b.hcount, bus_b.vcount} !== snap) chg++;
            if (bus_a.frame_start || bus_b.frame_start) fsh++;
        end
        cmp("hold_pos", {bus_a.hcount, bus_a.vcount}, {10'd100, 10'd1});
        cmp("hold_changes", 64'(chg), 64'd0);
        cmp("hold_fs", 64'(fsh), 64'd0);

        // Reduced-timing frame: 25 x 15 = 375 strobes, vsync on lines 10..11.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step_pix();
            if (fs_b_seen) found = 1'b1;
        end
        cmp("b_frame_found", 64'(found), 64'd1);
        n = 0; vlow = 0; vmin = 9999; vmax = -1; found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step_pix();
            n++;
            if (!bus_b.vsync) begin
                vlow++;
                if (int'(bus_b.vcount) < vmin) vmin = int'(bus_b.vcount);
                if (int'(bus_b.vcount) > vmax) vmax = int'(bus_b.vcount);
            end
            if (fs_b_seen) found = 1'b1;
        end
        cmp("b_frame_len", 64'(n), 64'd375);
        cmp("b_vsync_len", 64'(vlow), 64'd50);
        cmp("b_vsync_lines", {8'(vmin), 8'(vmax)}, {8'd10, 8'd11});

        for (int i = 0; i < 2 * AHT && bus_a.hcount != 10'd300; i++) step_pix();
        cmp("a_at_300", 64'(bus_a.hcount), 64'd300);
        @(negedge clk) rst = 1'b1;
        #1;
        cmp("async_rst_a", {bus_a.hcount, bus_a.vcount, bus_a.hsync, bus_a.vsync, bus_a.active, bus_a.frame_start},
                           {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk) pix_en = 1'b1;
        @(posedge clk) #1;
        cmp("restart_a", {bus_a.hcount, bus_a.vcount, bus_a.active, bus_a.frame_start}, {10'd0, 10'd0, 1'b1, 1'b1});
        @(negedge clk) pix_en = 1'b0;

        // pix_en held high: reduced frames start every 375 clks.
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(negedge clk) pix_en = 1'b1;
        nfs = 0; afs = 0; cyc = 0;
        for (int i = 0; i < 800 && nfs < 3; i++) begin
            @(posedge clk) #1;
            cyc++;
            if (bus_a.frame_start) afs++;
            if (bus_b.frame_start) begin
                fs_t[nfs] = cyc;
                nfs++;
            end
        end
        cmp("tied_fs_count", 64'(nfs), 64'd3);
`ifdef VGA_FRAME_CNT_EN
        cmp("frame_cnt_b", 64'(bus_b.frame_cnt), 64'd3);
        cmp("frame_cnt_a", 64'(bus_a.frame_cnt), 64'd1);
`endif
        if (nfs == 3) begin
            cmp("tied_first_fs", 64'(fs_t[0]), 64'd1);
            cmp("tied_spacing1", 64'(fs_t[1] - fs_t[0]), 64'd375);
            cmp("tied_spacing2", 64'(fs_t[2] - fs_t[1]), 64'd375);
        end
        cmp("tied_fs_a", 64'(afs), 64'd1);
        @(negedge clk) pix_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
